alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 14 +
 rtl/alu_seq.sv | 100 ++++++++++
 tb/tb_alu_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and registered result/flag bundle for alu_seq.
interface alu_seq_if;
    logic       start;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       CARRY;
    logic       ZERO;
    logic       busy;
    logic       done;
    modport master (output start, SELECT, DATA1, DATA2, input RESULT, CARRY, ZERO, busy, done);
    modport slave  (input start, SELECT, DATA1, DATA2, output RESULT, CARRY, ZERO, busy, done);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered 8-bit ALU with single-cycle ops and an optional 8-step shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the MUL datapath; otherwise SELECT=101 behaves as unsupported.
module alu_seq (
    input logic     clk,
    input logic     RESET,
    alu_seq_if.slave bus
);
    logic [7:0] res_q, res_d, op_res, mul_res;
    logic       carry_q, carry_d, zero_q, zero_d, done_q, done_d;
    logic       op_c, mul_c, single_go, mul_fin;
    logic [8:0] sum, diff;
    assign sum  = {1'b0, bus.DATA1} + {1'b0, bus.DATA2};
    assign diff = {1'b0, bus.DATA1} - {1'b0, bus.DATA2};
    always_comb begin
        op_res = 8'h00;
        op_c   = 1'b0;
        case (bus.SELECT)
            3'b000: op_res = bus.DATA2;
            3'b001: {op_c, op_res} = sum;
            3'b010: op_res = bus.DATA1 & bus.DATA2;
            3'b011: op_res = bus.DATA1 | bus.DATA2;
            3'b100: {op_c, op_res} = diff;
            default: op_res = 8'h00;
        endcase
    end
`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d, acc_nx;
    // one partial product per step, weighted by the current multiplier bit
    assign acc_nx    = acc_q + (b_q[cnt_q] ? {8'h00, a_q} << cnt_q : 16'h0000);
    assign single_go = state_q == IDLE && bus.start && bus.SELECT != 3'b101;
    assign mul_fin   = state_q == MUL_RUN && cnt_q == 3'd7;
    assign mul_res   = acc_nx[7:0];
    assign mul_c     = |acc_nx[15:8];
    assign bus.busy  = state_q == MUL_RUN;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (state_q == IDLE && bus.start && bus.SELECT == 3'b101) begin
            state_d = MUL_RUN;
            a_d     = bus.DATA1;
            b_d     = bus.DATA2;
            cnt_d   = 3'd0;
            acc_d   = 16'h0000;
        end else if (state_q == MUL_RUN) begin
            acc_d   = acc_nx;
            cnt_d   = cnt_q + 3'd1;
            state_d = mul_fin ? IDLE : MUL_RUN;
        end
    end
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cnt_q   <= 3'd0;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign single_go = bus.start;
    assign mul_fin   = 1'b0;
    assign mul_res   = 8'h00;
    assign mul_c     = 1'b0;
    assign bus.busy  = 1'b0;
`endif
    assign res_d   = single_go ? op_res : mul_fin ? mul_res : res_q;
    assign carry_d = single_go ? op_c : mul_fin ? mul_c : carry_q;
    assign zero_d  = single_go ? op_res == 8'h00 : mul_fin ? mul_res == 8'h00 : zero_q;
    assign done_d  = single_go | mul_fin;
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            res_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end
    assign bus.RESULT = res_q;
    assign bus.CARRY  = carry_q;
    assign bus.ZERO   = zero_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq checked against a cycle-level behavioural model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;
    alu_seq_if bus ();
    alu_seq dut (.clk(clk), .RESET(RESET), .bus(bus.slave));
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    int tests = 0;
    int fails = 0;
    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic logic [8:0] single(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'b000: single = {1'b0, b};
            3'b001: single = {1'b0, a} + {1'b0, b};
            3'b010: single = {1'b0, a & b};
            3'b011: single = {1'b0, a | b};
            3'b100: single = {b > a, a - b};
            default: single = 9'h000;
        endcase
    endfunction
    logic [7:0]  m_res = 8'h00, ma = 8'h00, mb = 8'h00;
    logic        m_c = 1'b0, m_z = 1'b1, m_done = 1'b0, m_busy = 1'b0;
    int          m_left = 0;
    logic [15:0] m_prod;
    logic [8:0]  m_single;
    assign m_prod   = 16'(ma) * 16'(mb);
    assign m_single = single(bus.SELECT, bus.DATA1, bus.DATA2);
    // model: a MUL completes eight edges after acceptance; starts are ignored until then
    always @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            m_res <= 8'h00; m_c <= 1'b0; m_z <= 1'b1; m_done <= 1'b0; m_busy <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_res <= m_prod[7:0]; m_c <= m_prod[15:8] != 0; m_z <= m_prod[7:0] == 0;
                    m_done <= 1'b1; m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                if (MUL_EN && bus.SELECT == 3'b101) begin
                    ma <= bus.DATA1; mb <= bus.DATA2; m_left <= 8; m_busy <= 1'b1;
                end else begin
                    m_res <= m_single[7:0]; m_c <= m_single[8]; m_z <= m_single[7:0] == 0; m_done <= 1'b1;
                end
            end
        end
    end
    always @(negedge clk) begin
        chk("done", 8'(bus.done), 8'(m_done));
        chk("busy", 8'(bus.busy), 8'(m_busy));
        chk("result", bus.RESULT, m_res);
        chk("carry", 8'(bus.CARRY), 8'(m_c));
        chk("zero", 8'(bus.ZERO), 8'(m_z));
    end
    task automatic op(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.SELECT = s; bus.DATA1 = a; bus.DATA2 = b;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask
    task automatic lit(input string n, input logic [7:0] r, input logic c, input logic z, input logic d);
        chk({n, "_res"}, bus.RESULT, r);
        chk({n, "_carry"}, 8'(bus.CARRY), 8'(c));
        chk({n, "_zero"}, 8'(bus.ZERO), 8'(z));
        chk({n, "_done"}, 8'(bus.done), 8'(d));
    endtask
    int busy_cnt, ndone;
    logic [7:0] cap_r;
    logic cap_c, cap_z;
    initial begin
        bus.start = 1'b0; bus.SELECT = 3'b000; bus.DATA1 = 8'h00; bus.DATA2 = 8'h00;
        #1 RESET = 1'b0;
        repeat (2) @(posedge clk);
        #2 lit("reset", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("reset_busy", 8'(bus.busy), 8'd0);
        RESET = 1'b1;
        op(3'b001, 8'hF0, 8'h20);
        lit("add", 8'h10, 1'b1, 1'b0, 1'b1);
        chk("add_busy", 8'(bus.busy), 8'd0);
        chk("model_add", m_res, 8'h10);
        @(posedge clk); #2 lit("add_after", 8'h10, 1'b1, 1'b0, 1'b0);
        op(3'b100, 8'h05, 8'h05); lit("sub_eq", 8'h00, 1'b0, 1'b1, 1'b1);
        op(3'b100, 8'h03, 8'h07); lit("sub_borrow", 8'hFC, 1'b1, 1'b0, 1'b1);
        chk("model_sub", m_res, 8'hFC);
        op(3'b000, 8'h11, 8'h5A); lit("fwd", 8'h5A, 1'b0, 1'b0, 1'b1);
        op(3'b010, 8'hF0, 8'h3C); lit("and", 8'h30, 1'b0, 1'b0, 1'b1);
        op(3'b011, 8'hF0, 8'h0C); lit("or", 8'hFC, 1'b0, 1'b0, 1'b1);
        op(3'b110, 8'hFF, 8'hFF); lit("op110", 8'h00, 1'b0, 1'b1, 1'b1);
        op(3'b001, 8'h7F, 8'h01); lit("add_nc", 8'h80, 1'b0, 1'b0, 1'b1);
        op(3'b111, 8'h12, 8'h34); lit("op111", 8'h00, 1'b0, 1'b1, 1'b1);
        op(3'b011, 8'h00, 8'h00); lit("or_zero", 8'h00, 1'b0, 1'b1, 1'b1);
        op(3'b000, 8'h00, 8'hC3);
        bus.DATA1 = 8'h01; bus.DATA2 = 8'h02; bus.SELECT = 3'b001;
        repeat (3) @(posedge clk);
        #2 lit("hold", 8'hC3, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.SELECT = 3'b001; bus.DATA1 = 8'hFF; bus.DATA2 = 8'h01;
        @(posedge clk); #2 lit("b2b_1", 8'h00, 1'b1, 1'b1, 1'b1);
        bus.SELECT = 3'b011; bus.DATA1 = 8'h0F; bus.DATA2 = 8'hF0;
        @(posedge clk); #2 lit("b2b_2", 8'hFF, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        op(3'b101, 8'h0C, 8'h0B);
        bus.DATA1 = 8'hFF; bus.DATA2 = 8'hFF;
        busy_cnt = 0;
        for (int i = 0; i < 20 && !bus.done; i++) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #2;
        end
        chk("mul_done_timeout", 8'(bus.done), 8'd1);
        chk("mul_busy_cycles", 8'(busy_cnt), 8'd8);
        lit("mul", 8'h84, 1'b0, 1'b0, 1'b1);
        chk("model_mul", m_res, 8'h84);
        @(posedge clk); #2 chk("mul_done_pulse", 8'(bus.done), 8'd0);
        op(3'b101, 8'h20, 8'h10);
        ndone = 0; cap_r = 8'hAA; cap_c = 1'b0; cap_z = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                ndone++; cap_r = bus.RESULT; cap_c = bus.CARRY; cap_z = bus.ZERO;
            end
            bus.start = (i == 2 || i == 4);
            bus.SELECT = 3'b001;
            @(posedge clk); #2;
        end
        chk("mul_ignore_ndone", 8'(ndone), 8'd1);
        chk("mul_ovf_res", cap_r, 8'h00);
        chk("mul_ovf_carry", 8'(cap_c), 8'd1);
        chk("mul_ovf_zero", 8'(cap_z), 8'd1);
        op(3'b000, 8'h00, 8'hA5);
        op(3'b101, 8'h33, 8'h44);
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        #1 lit("abort", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("abort_busy", 8'(bus.busy), 8'd0);
        repeat (2) @(posedge clk);
        #2 chk("abort_nodone", 8'(bus.done), 8'd0);
        RESET = 1'b1;
        op(3'b000, 8'h00, 8'h5A);
        lit("post_abort_fwd", 8'h5A, 1'b0, 1'b0, 1'b1);
`else
        op(3'b101, 8'h0C, 8'h0B);
        lit("mul_unsup", 8'h00, 1'b0, 1'b1, 1'b1);
        chk("mul_unsup_busy", 8'(bus.busy), 8'd0);
        @(posedge clk); #2 chk("mul_unsup_pulse", 8'(bus.done), 8'd0);
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
